// File: rtl/mesi_coherence_unit.sv
// MESI state tracker for LINES cache lines: combinational processor/snoop decode
// plus a per-line state array, with the processor update winning on index collision.
module mesi_coherence_unit #(
   parameter int unsigned LINES = 4,
   parameter int unsigned IDX_W = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               proc_valid,
   input  logic [2:0]         proc_op,
   input  logic [IDX_W-1:0]   proc_index,
   input  logic [1:0]         snoop_msg,
   input  logic [IDX_W-1:0]   snoop_index,
   output logic [1:0]         proc_state,
   output logic [1:0]         proc_next,
   output logic               mem_rden,
   output logic [1:0]         snoop_state,
   output logic [1:0]         snoop_next,
   output logic               mem_wren,
   output logic [2*LINES-1:0] line_states
);

   typedef enum logic [1:0] {
      StI = 2'b00,
      StM = 2'b01,
      StS = 2'b10,
      StE = 2'b11
   } mesi_e;

   localparam logic [1:0] OpWriteHit  = 2'b00;
   localparam logic [1:0] OpReadHit   = 2'b01;
   localparam logic [1:0] OpWriteMiss = 2'b10;
   localparam logic [1:0] OpReadMiss  = 2'b11;

   localparam logic [1:0] SnNa        = 2'b00;
   localparam logic [1:0] SnInval     = 2'b01;
   localparam logic [1:0] SnWriteMiss = 2'b10;
   localparam logic [1:0] SnReadMiss  = 2'b11;

   mesi_e lines_q [LINES];
   mesi_e lines_d [LINES];
   mesi_e proc_cur, proc_nxt, snoop_cur, snoop_nxt;

   // Loop-based lookup so an index beyond LINES matches nothing and reads as I.
   always_comb begin
      proc_cur  = StI;
      snoop_cur = StI;
      for (int i = 0; i < LINES; i++) begin
         if (proc_index == IDX_W'(i))  proc_cur  = lines_q[i];
         if (snoop_index == IDX_W'(i)) snoop_cur = lines_q[i];
      end
   end

   always_comb begin
      proc_nxt = proc_cur;
      mem_rden = 1'b0;
      if (proc_valid) begin
         unique case (proc_op[1:0])
            OpWriteHit:  proc_nxt = StM;
            OpReadHit:   proc_nxt = proc_cur;
            OpWriteMiss: proc_nxt = StM;
            OpReadMiss: begin
               proc_nxt = proc_op[2] ? StS : StE;
               mem_rden = 1'b1;
            end
            default:     proc_nxt = proc_cur;
         endcase
      end
   end

   always_comb begin
      snoop_nxt = snoop_cur;
      mem_wren  = 1'b0;
      unique case (snoop_msg)
         SnNa:        snoop_nxt = snoop_cur;
         SnInval:     snoop_nxt = StI;
         SnWriteMiss: begin
            snoop_nxt = StI;
            mem_wren  = (snoop_cur == StM);
         end
         SnReadMiss: begin
            snoop_nxt = (snoop_cur == StI) ? StI : StS;
            mem_wren  = (snoop_cur == StM);
         end
         default:     snoop_nxt = snoop_cur;
      endcase
   end

   // Processor update takes priority; the dropped snoop still drives mem_wren.
   always_comb begin
      for (int i = 0; i < LINES; i++) begin
         lines_d[i] = lines_q[i];
         if (proc_valid && (proc_index == IDX_W'(i))) begin
            lines_d[i] = proc_nxt;
         end else if ((snoop_msg != SnNa) && (snoop_index == IDX_W'(i))) begin
            lines_d[i] = snoop_nxt;
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < LINES; i++) begin
         if (rst) lines_q[i] <= StI;
         else     lines_q[i] <= lines_d[i];
      end
   end

   always_comb begin
      line_states = '0;
      for (int i = 0; i < LINES; i++) begin
         line_states[2*i +: 2] = lines_q[i];
      end
   end

   assign proc_state  = proc_cur;
   assign proc_next   = proc_nxt;
   assign snoop_state = snoop_cur;
   assign snoop_next  = snoop_nxt;

endmodule

// File: tb/tb_mesi_coherence_unit.sv
// Directed table-driven bench for mesi_coherence_unit, plus reset corner sequences.
module tb_mesi_coherence_unit;

   logic       clk = 1'b0;
   logic       rst;
   logic       proc_valid;
   logic [2:0] proc_op;
   logic [1:0] proc_index;
   logic [1:0] snoop_msg;
   logic [1:0] snoop_index;
   logic [1:0] proc_state, proc_next, snoop_state, snoop_next;
   logic       mem_rden, mem_wren;
   logic [7:0] line_states;

   int checks = 0;
   int errors = 0;

   mesi_coherence_unit #(.LINES(4), .IDX_W(2)) dut (
      .clk         (clk),
      .rst         (rst),
      .proc_valid  (proc_valid),
      .proc_op     (proc_op),
      .proc_index  (proc_index),
      .snoop_msg   (snoop_msg),
      .snoop_index (snoop_index),
      .proc_state  (proc_state),
      .proc_next   (proc_next),
      .mem_rden    (mem_rden),
      .snoop_state (snoop_state),
      .snoop_next  (snoop_next),
      .mem_wren    (mem_wren),
      .line_states (line_states)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       pv;
      logic [2:0] op;
      logic [1:0] pidx;
      logic [1:0] sm;
      logic [1:0] sidx;
      logic [1:0] ps;
      logic [1:0] pn;
      logic       rd;
      logic [1:0] ss;
      logic [1:0] sn;
      logic       wr;
      logic [7:0] ls;
   } vec_t;

   localparam int NVec = 16;
   vec_t vecs [NVec];

   task automatic check(input string name, input int idx, input logic [7:0] act,
                        input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s vec %0d: got %b expected %b", name, idx, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic pv, input logic [2:0] op,
                        input logic [1:0] pidx, input logic [1:0] sm, input logic [1:0] sidx);
      rst         = r;
      proc_valid  = pv;
      proc_op     = op;
      proc_index  = pidx;
      snoop_msg   = sm;
      snoop_index = sidx;
   endtask

   initial begin
      // Encoding I=00 M=01 S=10 E=11; line_states = {l3,l2,l1,l0}.
      //            pv    op      pidx   sm     sidx   ps     pn     rd    ss     sn     wr    ls
      vecs[0]  = '{1'b1, 3'b011, 2'd0, 2'b00, 2'd0, 2'b00, 2'b11, 1'b1, 2'b00, 2'b00, 1'b0, 8'b00_00_00_11};
      vecs[1]  = '{1'b1, 3'b000, 2'd0, 2'b00, 2'd0, 2'b11, 2'b01, 1'b0, 2'b11, 2'b11, 1'b0, 8'b00_00_00_01};
      vecs[2]  = '{1'b0, 3'b000, 2'd0, 2'b11, 2'd0, 2'b01, 2'b01, 1'b0, 2'b01, 2'b10, 1'b1, 8'b00_00_00_10};
      vecs[3]  = '{1'b1, 3'b111, 2'd1, 2'b00, 2'd1, 2'b00, 2'b10, 1'b1, 2'b00, 2'b00, 1'b0, 8'b00_00_10_10};
      vecs[4]  = '{1'b0, 3'b000, 2'd1, 2'b01, 2'd1, 2'b10, 2'b10, 1'b0, 2'b10, 2'b00, 1'b0, 8'b00_00_00_10};
      vecs[5]  = '{1'b1, 3'b111, 2'd1, 2'b00, 2'd1, 2'b00, 2'b10, 1'b1, 2'b00, 2'b00, 1'b0, 8'b00_00_10_10};
      vecs[6]  = '{1'b1, 3'b010, 2'd2, 2'b00, 2'd2, 2'b00, 2'b01, 1'b0, 2'b00, 2'b00, 1'b0, 8'b00_01_10_10};
      vecs[7]  = '{1'b1, 3'b010, 2'd2, 2'b10, 2'd2, 2'b01, 2'b01, 1'b0, 2'b01, 2'b00, 1'b1, 8'b00_01_10_10};
      vecs[8]  = '{1'b1, 3'b011, 2'd3, 2'b00, 2'd3, 2'b00, 2'b11, 1'b1, 2'b00, 2'b00, 1'b0, 8'b11_01_10_10};
      vecs[9]  = '{1'b1, 3'b001, 2'd3, 2'b01, 2'd0, 2'b11, 2'b11, 1'b0, 2'b10, 2'b00, 1'b0, 8'b11_01_10_00};
      vecs[10] = '{1'b1, 3'b101, 2'd1, 2'b10, 2'd3, 2'b10, 2'b10, 1'b0, 2'b11, 2'b00, 1'b0, 8'b00_01_10_00};
      vecs[11] = '{1'b1, 3'b100, 2'd1, 2'b11, 2'd2, 2'b10, 2'b01, 1'b0, 2'b01, 2'b10, 1'b1, 8'b00_10_01_00};
      vecs[12] = '{1'b1, 3'b110, 2'd0, 2'b11, 2'd3, 2'b00, 2'b01, 1'b0, 2'b00, 2'b00, 1'b0, 8'b00_10_01_01};
      vecs[13] = '{1'b0, 3'b011, 2'd2, 2'b11, 2'd1, 2'b10, 2'b10, 1'b0, 2'b01, 2'b10, 1'b1, 8'b00_10_10_01};
      vecs[14] = '{1'b0, 3'b000, 2'd0, 2'b10, 2'd1, 2'b01, 2'b01, 1'b0, 2'b10, 2'b00, 1'b0, 8'b00_10_00_01};
      vecs[15] = '{1'b1, 3'b011, 2'd0, 2'b01, 2'd0, 2'b01, 2'b11, 1'b1, 2'b01, 2'b00, 1'b0, 8'b00_10_00_11};

      // Reset, then idle: every output must be zero.
      drive(1'b1, 1'b0, 3'b000, 2'd0, 2'b00, 2'd0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 3'b000, 2'd0, 2'b00, 2'd0);
      #1;
      check("reset_line_states", -1, line_states, 8'h00);
      check("reset_outputs", -1,
            {proc_state, proc_next, snoop_state, snoop_next},
            8'h00);
      check("reset_mem", -1, 8'({mem_rden, mem_wren}), 8'h00);

      for (int i = 0; i < NVec; i++) begin
         drive(1'b0, vecs[i].pv, vecs[i].op, vecs[i].pidx, vecs[i].sm, vecs[i].sidx);
         #1;
         check("proc_state",  i, 8'(proc_state),  8'(vecs[i].ps));
         check("proc_next",   i, 8'(proc_next),   8'(vecs[i].pn));
         check("mem_rden",    i, 8'(mem_rden),    8'(vecs[i].rd));
         check("snoop_state", i, 8'(snoop_state), 8'(vecs[i].ss));
         check("snoop_next",  i, 8'(snoop_next),  8'(vecs[i].sn));
         check("mem_wren",    i, 8'(mem_wren),    8'(vecs[i].wr));
         @(posedge clk); #1;
         check("line_states", i, line_states, vecs[i].ls);
      end

      // Line 0 to M, then reset in the same cycle as a write_hit and a snoop.
      drive(1'b0, 1'b1, 3'b000, 2'd0, 2'b00, 2'd0);
      @(posedge clk); #1;
      check("seq_line0_m", 100, line_states, 8'b00_10_00_01);
      drive(1'b1, 1'b1, 3'b000, 2'd0, 2'b11, 2'd2);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 3'b000, 2'd0, 2'b00, 2'd0);
      #1;
      check("rst_override", 101, line_states, 8'h00);
      check("rst_idle_outputs", 101,
            {proc_state, proc_next, snoop_state, snoop_next}, 8'h00);
      check("rst_idle_mem", 101, 8'({mem_rden, mem_wren}), 8'h00);

      // Idle processor holds state across an edge.
      drive(1'b0, 1'b1, 3'b011, 2'd2, 2'b00, 2'd0);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 3'b010, 2'd2, 2'b00, 2'd0);
      #1;
      check("idle_proc_next", 102, 8'({proc_next, mem_rden}), 8'({2'b11, 1'b0}));
      @(posedge clk); #1;
      check("idle_hold", 102, line_states, 8'b00_11_00_00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mesi_coherence_unit.md
MESI_COHERENCE_UNIT -- requirements
Module: mesi_coherence_unit

Interface
REQ-001 SHALL have parameter LINES, default 4, meaning the number of cache lines tracked.
REQ-002 SHALL have parameter IDX_W, default 2, meaning the line-index width, equal to log2(LINES).
REQ-003 clk  input  1  single clock; every register updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 proc_valid  input  1  a processor request is present this cycle.
REQ-006 proc_op  input  3  bit2 = shared flag; bits1:0 = 00 write_hit, 01 read_hit, 10 write_miss, 11 read_miss.
REQ-007 proc_index  input  IDX_W  line index addressed by the processor.
REQ-008 snoop_msg  input  2  bus message: 00 NA, 01 bus_invalidate, 10 bus_write_miss, 11 bus_read_miss.
REQ-009 snoop_index  input  IDX_W  line index addressed by the snooped bus message.
REQ-010 proc_state  output  2  current state of line proc_index.
REQ-011 proc_next  output  2  processor-side next state of that line.
REQ-012 mem_rden  output  1  memory read request.
REQ-013 snoop_state  output  2  current state of line snoop_index.
REQ-014 snoop_next  output  2  snoop-side next state of that line.
REQ-015 mem_wren  output  1  memory write-back request.
REQ-016 line_states  output  2*LINES  all line states; line i occupies bits [2i+1:2i].

Function
REQ-017 State encoding SHALL be I=00, M=01, S=10, E=11; states are held in a LINES-entry register array.
REQ-018 proc_state, snoop_state, proc_next, snoop_next, mem_rden and mem_wren SHALL be purely combinational from the array and the current inputs.
REQ-019 When proc_valid=0, the processor side SHALL be idle: proc_next = proc_state, mem_rden=0.
REQ-020 On read_hit: proc_next = proc_state, mem_rden=0.
REQ-021 On write_hit: proc_next=M, mem_rden=0 for any current state (invalidate broadcast is the caller's duty).
REQ-022 On write_miss: proc_next=M, mem_rden=0 (full-word write, no fetch).
REQ-023 On read_miss with proc_op[2]=0: proc_next=E, mem_rden=1.
REQ-024 On read_miss with proc_op[2]=1: proc_next=S, mem_rden=1.
REQ-025 proc_op[2] SHALL be ignored for every op other than read_miss.
REQ-026 Snoop NA: snoop_next = snoop_state, mem_wren=0.
REQ-027 Snoop bus_invalidate: snoop_next=I, mem_wren=0.
REQ-028 Snoop bus_write_miss: snoop_next=I; mem_wren=1 only if snoop_state=M.
REQ-029 Snoop bus_read_miss: M->S with mem_wren=1; E->S, S->S and I->I with mem_wren=0.
REQ-030 At each rising edge with proc_valid=1, line[proc_index] SHALL load proc_next.
REQ-031 At each rising edge with snoop_msg!=NA, line[snoop_index] SHALL load snoop_next, unless proc_valid=1 and snoop_index=proc_index, in which case the processor update wins and the snoop update is dropped.
REQ-032 mem_wren SHALL still reflect the snoop decode when the snoop update is dropped by REQ-031.
REQ-033 Updates to two different indices in the same cycle SHALL both take effect.
REQ-034 proc_index and snoop_index values >= LINES SHALL cause no state change.

Reset
REQ-035 On the rising edge with rst=1, every line SHALL become I; rst SHALL override all same-cycle updates.
REQ-036 After reset with all request inputs idle, every output SHALL be 0.
REQ-037 Reset asserted mid-operation SHALL discard any pending update.

Verification
REQ-038 Reset, then proc_valid=1, proc_op=011, proc_index=0 -> mem_rden=1, proc_next=E; line 0 = E after the edge.
REQ-039 Line 0 = E, proc_op=000 -> line 0 = M; then snoop_msg=11, snoop_index=0 -> mem_wren=1 combinationally, line 0 = S after the edge.
REQ-040 Line 1 = S, snoop_msg=01, snoop_index=1 -> line 1 = I, mem_wren=0; then proc_op=111 on line 1 -> line 1 = S, mem_rden=1.
REQ-041 Same cycle: proc write_miss on index 2, snoop bus_write_miss on index 2 (line 2 = M) -> line 2 = M, mem_wren=1.
REQ-042 Same cycle: proc read_hit on index 3 (line 3 = E), snoop bus_invalidate on index 0 (line 0 = S) -> line 3 = E, line 0 = I.
REQ-043 Line 0 = M, rst=1 in the same cycle as proc_op=000 on index 0 -> all lines I and line_states=0 after the edge.
